// File: rtl/dds_oscillator.sv
// -----------------------------------------------------------------------------
// dds_oscillator
//
// Direct digital synthesis oscillator. A free-running divider produces a
// one-cycle sample tick every clk_freq_p/sample_rate_p clocks. On each tick the
// current phase is turned into one sample of the selected waveform (sine,
// square, triangle or sawtooth) and the phase accumulator advances by an
// increment derived from the requested frequency in Hz.
//
// Ports
//   clk_i        : single clock, all state updates on the rising edge
//   reset_i      : synchronous, active-high reset (dominates everything)
//   freq_ctrl_i  : requested output frequency in Hz (clamped to Nyquist)
//   wave_sel_i   : 00 sine, 01 square, 10 triangle, 11 sawtooth
//   duty_i       : square-wave high fraction = duty_i/256
//   sync_i       : phase restart pulse
//   ready_i      : downstream accepts the sample on data_o
//   data_o       : current signed sample
//   valid_o      : data_o holds a sample not yet consumed
//   overrun_o    : sticky, set when a new sample had to be dropped
//
// Handshake: a sample is consumed in any cycle where valid_o && ready_i. While
// valid_o is high and ready_i is low, data_o is held stable. A tick that finds
// an unconsumed sample with no handshake in the same cycle drops the new
// sample (the phase still advances) and sets overrun_o.
// -----------------------------------------------------------------------------
module dds_oscillator #(
    parameter int width_p       = 12,
    parameter int clk_freq_p    = 12_000_000,
    parameter int sample_rate_p = 48_000,
    parameter int phase_width_p = 24,
    parameter int lut_log2_p    = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [15:0]               freq_ctrl_i,
    input  logic [1:0]                wave_sel_i,
    input  logic [7:0]                duty_i,
    input  logic                      sync_i,
    input  logic                      ready_i,
    output logic signed [width_p-1:0] data_o,
    output logic                      valid_o,
    output logic                      overrun_o
);

    // ------------------------------------------------------------------
    // Elaboration constants
    // ------------------------------------------------------------------
    localparam int N_LP     = clk_freq_p / sample_rate_p;
    localparam int CNT_W_LP = (N_LP > 1) ? $clog2(N_LP) : 1;
    localparam logic [CNT_W_LP-1:0] CNT_MAX_LP = CNT_W_LP'(N_LP - 1);

    // Phase increment per Hz, scaled by 2^16 so the per-tick increment can be
    // rounded after the multiply: K = round(2^(phase_width_p+16)/sample_rate_p).
    localparam logic [63:0] K_LP =
        ((64'd1 << (phase_width_p + 16)) + 64'(sample_rate_p / 2)) / 64'(sample_rate_p);

    localparam int LUT_N_LP = 1 << lut_log2_p;

    localparam logic [width_p-1:0] HALF_LP   = {1'b1, {(width_p-1){1'b0}}};
    localparam logic [width_p-1:0] SQ_POS_LP = {1'b0, {(width_p-1){1'b1}}};
    localparam logic [width_p-1:0] SQ_NEG_LP = {1'b1, {(width_p-2){1'b0}}, 1'b1};

    // pi * 2^30, the fixed-point scale used to build the sine table.
    localparam longint PI_Q30_LP = 64'sd3373259426;

    // Quarter-wave sine entry i = round(A*sin(pi/2*(i+0.5)/2^lut_log2_p)),
    // A = 2^(width_p-1)-1, evaluated with an integer Taylor series in Q30 so
    // the table is built entirely at elaboration time.
    function automatic longint sine_entry(input int idx);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint amp;
        x    = (PI_Q30_LP * longint'(2 * idx + 1)) >>> (lut_log2_p + 2);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = (term * x2) >>> 30;
            term = term / longint'((2 * k) * (2 * k + 1));
            if ((k % 2) == 1) begin
                sum = sum - term;
            end else begin
                sum = sum + term;
            end
        end
        amp = (longint'(1) <<< (width_p - 1)) - 1;
        return (amp * sum + (longint'(1) <<< 29)) >>> 30;
    endfunction

    // Quarter-wave magnitude table (all entries are non-negative).
    logic [width_p-2:0] lut_w [LUT_N_LP];

    for (genvar g = 0; g < LUT_N_LP; g++) begin : g_lut
        localparam longint ENTRY_LP = sine_entry(g);
        assign lut_w[g] = (width_p-1)'(ENTRY_LP);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W_LP-1:0]      cnt_q,     cnt_d;
    logic [phase_width_p-1:0] phase_q,   phase_d;
    logic [width_p-1:0]       data_q,    data_d;
    logic                     valid_q,   valid_d;
    logic                     overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                     tick;
    logic [15:0]              freq_c;
    logic [63:0]              prod;
    logic [phase_width_p-1:0] inc;
    logic [phase_width_p-1:0] phase_s;
    logic [width_p-1:0]       u;
    logic [7:0]               top8;
    logic [1:0]               quad;
    logic [lut_log2_p-1:0]    lut_idx;
    logic [width_p-1:0]       sine_mag;
    logic [width_p-1:0]       sine_val;
    logic [width_p-1:0]       sq_val;
    logic [width_p-1:0]       tri_v;
    logic [width_p-1:0]       tri_val;
    logic [width_p-1:0]       saw_val;
    logic [width_p-1:0]       sample;

    assign tick = (cnt_q == CNT_MAX_LP);

    always_comb begin
        // Clamp to Nyquist before scaling.
        freq_c = freq_ctrl_i;
        if (32'(freq_ctrl_i) > 32'(sample_rate_p / 2)) begin
            freq_c = 16'(sample_rate_p / 2);
        end
        prod = 64'(freq_c) * K_LP;
        inc  = phase_width_p'((prod + 64'd32768) >> 16);

        // A sync pulse restarts from phase 0; when it lands on a tick the
        // sample is taken from phase 0 and the accumulator leaves at inc.
        phase_s = sync_i ? '0 : phase_q;

        u    = width_p'(phase_s >> (phase_width_p - width_p));
        top8 = 8'(phase_s >> (phase_width_p - 8));
        quad = 2'(phase_s >> (phase_width_p - 2));

        // Odd quadrants walk the table backwards, the lower half is negated.
        lut_idx = lut_log2_p'(phase_s >> (phase_width_p - 2 - lut_log2_p));
        if (quad[0]) begin
            lut_idx = ~lut_idx;
        end
        sine_mag = {1'b0, lut_w[lut_idx]};
        sine_val = quad[1] ? (-sine_mag) : sine_mag;

        sq_val  = (top8 < duty_i) ? SQ_POS_LP : SQ_NEG_LP;

        tri_v   = u[width_p-1] ? ((~u) << 1) : (u << 1);
        tri_val = tri_v - HALF_LP;

        saw_val = u - HALF_LP;

        case (wave_sel_i)
            2'b00:   sample = sine_val;
            2'b01:   sample = sq_val;
            2'b10:   sample = tri_val;
            default: sample = saw_val;
        endcase

        // A zero frequency request mutes the output.
        if (freq_ctrl_i == 16'd0) begin
            sample = '0;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = tick ? '0 : (cnt_q + CNT_W_LP'(1));
        phase_d   = tick ? (phase_s + inc) : phase_s;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (tick) begin
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = sample;
                valid_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            phase_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = $signed(data_q);
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_dds_oscillator.sv
// -----------------------------------------------------------------------------
// tb_dds_oscillator
//
// Bench for dds_oscillator at clk 192 kHz, 48 kHz sample rate (4 clocks per
// sample), 12-bit samples, 24-bit phase. A behavioural model tracks the
// expected outputs every cycle from the waveform formulas; directed sequences
// additionally compare captured samples against literal expected values.
// -----------------------------------------------------------------------------
module tb_dds_oscillator;

  localparam int W     = 12;
  localparam int CLK_F = 192_000;
  localparam int SR    = 48_000;
  localparam int PW    = 24;
  localparam int LL    = 8;
  localparam int N     = CLK_F / SR;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [15:0]         freq;
  logic [1:0]          wave;
  logic [7:0]          duty;
  logic                sync;
  logic                ready;
  logic signed [W-1:0] data;
  logic                valid;
  logic                ovr;

  dds_oscillator #(
    .width_p       (W),
    .clk_freq_p    (CLK_F),
    .sample_rate_p (SR),
    .phase_width_p (PW),
    .lut_log2_p    (LL)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .freq_ctrl_i (freq),
    .wave_sel_i  (wave),
    .duty_i      (duty),
    .sync_i      (sync),
    .ready_i     (ready),
    .data_o      (data),
    .valid_o     (valid),
    .overrun_o   (ovr)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  longint k_m;
  longint m_phase;
  int     m_age;
  longint m_data;
  bit     m_valid;
  bit     m_ovr;

  function automatic longint model_inc(input int f);
    longint fc;
    fc = f;
    if (fc > SR / 2) fc = SR / 2;
    return ((fc * k_m + 32768) >> 16) & ((longint'(1) << PW) - 1);
  endfunction

  function automatic longint model_sample(input longint ph, input int w, input int d, input int f);
    longint u;
    longint v;
    longint q;
    longint idx;
    longint m;
    real    mag;
    if (f == 0) return 0;
    u = ph >> (PW - W);
    case (w)
      0: begin
        q   = ph >> (PW - 2);
        idx = (ph >> (PW - 2 - LL)) % (1 << LL);
        m   = (q % 2 == 1) ? ((1 << LL) - 1 - idx) : idx;
        mag = $floor(2047.0 * $sin(3.141592653589793 / 2.0 * (real'(m) + 0.5) / real'(1 << LL)) + 0.5);
        return (q >= 2) ? -longint'(mag) : longint'(mag);
      end
      1: return ((ph >> (PW - 8)) < d) ? 2047 : -2047;
      2: begin
        v = (u < 2048) ? 2 * u : 2 * (4095 - u);
        return v - 2048;
      end
      default: return u - 2048;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock with the inputs currently applied, model + compare
  // ---------------------------------------------------------------------------
  task automatic cycle();
    bit     due;
    bit     loaded;
    longint start;
    loaded = 1'b0;
    if (reset) begin
      m_age   = 0;
      m_phase = 0;
      m_data  = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      due   = (m_age % N) == (N - 1);
      m_age = m_age + 1;
      start = sync ? 0 : m_phase;
      if (due) begin
        if (m_valid && !ready) begin
          m_ovr = 1'b1;
        end else begin
          m_data  = model_sample(start, int'(wave), int'(duty), int'(freq));
          m_valid = 1'b1;
          loaded  = 1'b1;
        end
        m_phase = (start + model_inc(int'(freq))) % (longint'(1) << PW);
      end else begin
        if (m_valid && ready) m_valid = 1'b0;
        m_phase = start;
      end
    end
    @(posedge clk);
    #1;
    check_val("data", longint'(data), m_data);
    check_val("valid", longint'(valid), longint'(m_valid));
    check_val("overrun", longint'(ovr), longint'(m_ovr));
    if (loaded) got_q.push_back(data);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic expect_seq(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        check_val(tag, longint'($signed(g)), longint'($signed(e)));
      end else begin
        check_val({tag, "_missing"}, 99999, longint'($signed(e)));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    k_m     = longint'($floor((2.0 ** (PW + 16)) / real'(SR) + 0.5));
    m_age   = 0;
    m_phase = 0;
    m_data  = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;

    reset = 1'b1;
    freq  = 16'd12000;
    wave  = 2'b11;
    duty  = 8'd128;
    sync  = 1'b0;
    ready = 1'b1;
    @(negedge clk);

    // Reset state
    run(3);
    check_val("rst_data", longint'(data), 0);
    check_val("rst_valid", longint'(valid), 0);
    check_val("rst_ovr", longint'(ovr), 0);

    // Sawtooth at 12 kHz, first sample lands N cycles after reset release
    reset = 1'b0;
    got_q.delete();
    run(3);
    check_val("first_lat_lo", longint'(valid), 0);
    run(1);
    check_val("first_lat_hi", longint'(valid), 1);
    run(28);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(W'(-2048));
      exp_q.push_back(W'(-1024));
      exp_q.push_back(W'(0));
      exp_q.push_back(W'(1024));
    end
    expect_seq("saw12k");

    // Square 50 % duty
    wave = 2'b01;
    do_reset();
    run(16);
    exp_q.push_back(W'(2047));
    exp_q.push_back(W'(2047));
    exp_q.push_back(W'(-2047));
    exp_q.push_back(W'(-2047));
    expect_seq("square");

    // Triangle
    wave = 2'b10;
    do_reset();
    run(16);
    exp_q.push_back(W'(-2048));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(2046));
    exp_q.push_back(W'(-2));
    expect_seq("triangle");

    // Back-pressure across three ticks
    wave  = 2'b11;
    ready = 1'b0;
    do_reset();
    run(4);
    check_val("bp1_valid", longint'(valid), 1);
    check_val("bp1_ovr", longint'(ovr), 0);
    run(4);
    check_val("bp2_ovr", longint'(ovr), 1);
    run(4);
    check_val("bp3_data", longint'(data), -2048);
    check_val("bp3_valid", longint'(valid), 1);
    check_val("bp3_ovr", longint'(ovr), 1);
    ready = 1'b1;
    run(8);
    check_val("ovr_sticky", longint'(ovr), 1);

    // Reset while a sample is pending and overrun is set
    ready = 1'b0;
    run(4);
    check_val("pre_rst_valid", longint'(valid), 1);
    check_val("pre_rst_ovr", longint'(ovr), 1);
    reset = 1'b1;
    run(1);
    check_val("rst2_data", longint'(data), 0);
    check_val("rst2_valid", longint'(valid), 0);
    check_val("rst2_ovr", longint'(ovr), 0);
    reset = 1'b0;
    ready = 1'b1;
    got_q.delete();
    run(3);
    check_val("rst2_lat_lo", longint'(valid), 0);
    run(1);
    check_val("rst2_lat_data", longint'(data), -2048);
    check_val("rst2_lat_valid", longint'(valid), 1);

    // Sync pulse between ticks
    run(4);
    got_q.delete();
    while ((m_age % N) != 1) cycle();
    sync = 1'b1;
    run(1);
    sync = 1'b0;
    run(8);
    exp_q.push_back(W'(-2048));
    exp_q.push_back(W'(-1024));
    expect_seq("sync_mid");

    // Sync pulse coincident with a tick
    got_q.delete();
    while ((m_age % N) != (N - 1)) cycle();
    sync = 1'b1;
    run(1);
    sync = 1'b0;
    run(4);
    exp_q.push_back(W'(-2048));
    exp_q.push_back(W'(-1024));
    expect_seq("sync_tick");

    // Zero frequency mutes and holds phase, then resumes
    freq = 16'd0;
    got_q.delete();
    run(12);
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(0));
    expect_seq("freq0");
    freq = 16'd12000;
    run(8);

    // Above Nyquist is clamped
    freq = 16'd30000;
    do_reset();
    run(16);
    exp_q.push_back(W'(-2048));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(-2048));
    exp_q.push_back(W'(0));
    expect_seq("clamp");

    // Sine at 12 kHz: one quarter-wave step per sample
    wave = 2'b00;
    freq = 16'd12000;
    do_reset();
    run(16);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0:       freq = 16'd0;
        1:       freq = 16'($urandom_range(24001, 65535));
        2:       freq = 16'd12000;
        default: freq = 16'($urandom_range(1, 24000));
      endcase
      wave  = 2'($urandom_range(0, 3));
      duty  = 8'($urandom_range(0, 255));
      ready = ($urandom_range(0, 9) < 7);
      sync  = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;
    sync  = 1'b0;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_oscillator.md
DDS_OSCILLATOR -- requirements
Module: dds_oscillator

Interface
REQ-001 SHALL have parameter width_p, default 12: signed sample width.
REQ-002 SHALL have parameter clk_freq_p, default 12_000_000: clk_i frequency in Hz.
REQ-003 SHALL have parameter sample_rate_p, default 48_000: output sample rate in Hz; clk_freq_p >= 2*sample_rate_p.
REQ-004 SHALL have parameter phase_width_p, default 24: phase accumulator width; phase_width_p >= width_p+2.
REQ-005 SHALL have parameter lut_log2_p, default 8: log2 of sine quarter-wave table entries.
REQ-006 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port freq_ctrl_i, input, 16: requested output frequency in Hz.
REQ-009 SHALL have port wave_sel_i, input, 2: 00 sine, 01 square, 10 triangle, 11 sawtooth.
REQ-010 SHALL have port duty_i, input, 8: square high fraction = duty_i/256.
REQ-011 SHALL have port sync_i, input, 1: phase restart pulse.
REQ-012 SHALL have port ready_i, input, 1: downstream accepts sample.
REQ-013 SHALL have port data_o, output, width_p, signed: current sample.
REQ-014 SHALL have port valid_o, output, 1: data_o holds an unconsumed sample.
REQ-015 SHALL have port overrun_o, output, 1: sticky flag, a sample was dropped.

Function
REQ-016 SHALL generate tick for one cycle every N = clk_freq_p/sample_rate_p (integer) cycles, using a counter 0..N-1 with tick at N-1, then wrap to 0.
REQ-017 SHALL compute increment inc = (freq_ctrl_i*K + 2^15) >> 16, K = round(2^(phase_width_p+16)/sample_rate_p) as an elaboration constant; freq_ctrl_i above sample_rate_p/2 SHALL be clamped to floor(sample_rate_p/2).
REQ-018 SHALL sample freq_ctrl_i, wave_sel_i, duty_i only on tick; changes between ticks have no effect; phase SHALL NOT reset on changes (phase-continuous).
REQ-019 SHALL on tick, register a sample computed from current phase into data_o, then phase <= phase + inc modulo 2^phase_width_p; data_o/valid_o visible the cycle after tick.
REQ-020 SHALL use u = top width_p bits of phase (unsigned); saw = u - 2^(width_p-1).
REQ-021 SHALL output square = +(2^(width_p-1)-1) when phase top 8 bits < duty_i, else -(2^(width_p-1)-1); duty_i=0 gives constant negative.
REQ-022 SHALL output triangle = v - 2^(width_p-1), v = (u<<1) if u MSB=0 else ((~u)<<1), truncated to width_p bits.
REQ-023 SHALL output sine from quarter-wave LUT, entry i = round((2^(width_p-1)-1)*sin(pi/2*(i+0.5)/2^lut_log2_p)), indexed by phase bits below the top two, mirrored/negated by the top two bits.
REQ-024 SHALL hold phase and output 0 samples when freq_ctrl_i = 0 (still ticks, still valid).
REQ-025 SHALL keep data_o stable while valid_o=1 and ready_i=0; valid_o SHALL clear the cycle after valid_o&&ready_i unless a tick loads a new sample that same cycle.
REQ-026 SHALL on tick with valid_o=1 and ready_i=0 drop the new sample, keep old data_o, still advance phase, and set overrun_o=1.
REQ-027 SHALL on tick coincident with handshake load the new sample, valid_o stays 1, no overrun.
REQ-028 SHALL on sync_i=1 set phase to 0 at next edge; sync_i coincident with tick computes sample from phase 0 and leaves phase = inc.

Reset
REQ-029 SHALL on reset_i=1 set phase=0, tick counter=0, data_o=0, valid_o=0, overrun_o=0 at next edge, abandoning any pending sample; reset dominates tick, sync_i and handshake.
REQ-030 SHALL produce first tick N cycles after reset_i deasserts.

Verification (clk_freq_p=192_000, sample_rate_p=48_000, N=4, width_p=12, phase_width_p=24)
REQ-031 SHALL cover: freq 12000, saw, ready_i=1 -> inc=4194304, data_o sequence -2048,-1024,0,1024 repeating, valid_o one sample per 4 cycles.
REQ-032 SHALL cover: freq 12000, square, duty_i=128 -> +2047,+2047,-2047,-2047; triangle -> -2048,0,2046,-2.
REQ-033 SHALL cover: ready_i=0 across 3 ticks -> data_o held at first sample, valid_o=1, overrun_o=1 after second tick and stays set until reset.
REQ-034 SHALL cover: sync_i pulse mid-stream (saw) -> next sample -2048, followed by -1024.
REQ-035 SHALL cover: freq_ctrl_i=0 -> repeated 0 samples; freq_ctrl_i=30000 -> clamped inc=2^23, saw alternates -2048,0.
REQ-036 SHALL cover: reset_i asserted with valid_o=1 and overrun_o=1 -> all outputs 0 next cycle, first new sample -2048 (saw) after 4 cycles.
